// File: rtl/even_cnt_checker.sv
// even_cnt_checker: watches a run-gated counter that steps by two
// (0,2,...,14) and reports lock, sequence violations and wrap events.
// Acquisition needs LOCK_CNT consecutive matching samples after an anchor.
// Every output is registered, and an async active-low reset clears all state.

module even_cnt_checker #(
    parameter int LOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    input  logic       run,
    output logic       locked,
    output logic       err,
    output logic       wrap,
    output logic [3:0] err_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_ACQ    = 2'b01,
        ST_LOCKED = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

    // Value the counter should show now, given what it showed and saw last cycle.
    function automatic logic [3:0] next_expected(input logic [3:0] cnt, input logic r);
        logic [3:0] v;
        if (r) begin
            v = cnt + 4'd2;
        end else begin
            v = cnt;
        end
        return v;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] good_cnt_r;
    logic [2:0] good_cnt_nxt_s;
    logic [3:0] prev_cnt_r;
    logic       prev_run_r;
    logic       locked_r;
    logic       err_r;
    logic       wrap_r;
    logic [3:0] err_cnt_r;
    logic [3:0] err_cnt_nxt_s;
    logic       err_s;
    logic       wrap_s;
    logic [3:0] exp_s;
    logic       match_s;
    logic       wrap_hit_s;

    assign exp_s      = next_expected(prev_cnt_r, prev_run_r);
    // An odd sample can never be a legal counter value.
    assign match_s    = (cnt_in == exp_s) && (cnt_in[0] == 1'b0);
    assign wrap_hit_s = (prev_cnt_r == 4'd14) && prev_run_r && (cnt_in == 4'd0);

    // Next-state, acquisition counter and pulse decode.
    always_comb begin
        state_nxt_s    = state_r;
        good_cnt_nxt_s = good_cnt_r;
        err_cnt_nxt_s  = err_cnt_r;
        err_s          = 1'b0;
        wrap_s         = 1'b0;
        case (state_r)
            ST_HUNT: begin
                // First edge after reset only anchors prev_cnt/prev_run.
                state_nxt_s    = ST_ACQ;
                good_cnt_nxt_s = 3'd0;
            end
            ST_ACQ: begin
                if (match_s) begin
                    if ((good_cnt_r + 3'd1) >= LOCK_TGT) begin
                        state_nxt_s    = ST_LOCKED;
                        good_cnt_nxt_s = 3'd0;
                    end else begin
                        good_cnt_nxt_s = good_cnt_r + 3'd1;
                    end
                end else begin
                    good_cnt_nxt_s = 3'd0;
                end
            end
            ST_LOCKED: begin
                if (match_s) begin
                    wrap_s = wrap_hit_s;
                end else begin
                    state_nxt_s = ST_ERROR;
                    err_s       = 1'b1;
                    if (err_cnt_r == 4'd15) begin
                        err_cnt_nxt_s = 4'd15;
                    end else begin
                        err_cnt_nxt_s = err_cnt_r + 4'd1;
                    end
                end
            end
            ST_ERROR: begin
                // One-cycle recovery; this sample re-anchors the sequence.
                state_nxt_s    = ST_ACQ;
                good_cnt_nxt_s = 3'd0;
            end
            default: begin
                state_nxt_s    = ST_HUNT;
                good_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // State, history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_HUNT;
            good_cnt_r <= 3'd0;
            prev_cnt_r <= 4'd0;
            prev_run_r <= 1'b0;
            locked_r   <= 1'b0;
            err_r      <= 1'b0;
            wrap_r     <= 1'b0;
            err_cnt_r  <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            good_cnt_r <= good_cnt_nxt_s;
            prev_cnt_r <= cnt_in;
            prev_run_r <= run;
            locked_r   <= (state_nxt_s == ST_LOCKED);
            err_r      <= err_s;
            wrap_r     <= wrap_s;
            err_cnt_r  <= err_cnt_nxt_s;
        end
    end

    assign locked  = locked_r;
    assign err     = err_r;
    assign wrap    = wrap_r;
    assign err_cnt = err_cnt_r;
    assign state   = state_r;

endmodule

// File: tb/tb_even_cnt_checker.sv
// Bench for even_cnt_checker: directed scenarios plus a randomized walk,
// all compared against a behavioural model of the checker's rules.

module tb_even_cnt_checker;

    localparam int LOCK_CNT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       run = 1'b0;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [3:0] err_cnt;
    logic [1:0] state;

    even_cnt_checker #(.LOCK_CNT(LOCK_CNT)) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .run     (run),
        .locked  (locked),
        .err     (err),
        .wrap    (wrap),
        .err_cnt (err_cnt),
        .state   (state)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0=HUNT 1=ACQ 2=LOCKED 3=ERROR
    int m_state, m_good, m_prev, m_prun, m_errcnt, m_err, m_wrap;
    int last_cnt, last_run;
    int err_pulses, wrap_pulses;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_good = 0; m_prev = 0; m_prun = 0;
        m_errcnt = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(input int c, input int r);
        int  expv;
        bit  ok;
        expv   = (m_prun != 0) ? (m_prev + 2) % 16 : m_prev;
        ok     = (c == expv) && (c % 2 == 0);
        m_err  = 0;
        m_wrap = 0;
        if (m_state == 0) begin
            m_state = 1; m_good = 0;
        end else if (m_state == 1) begin
            if (ok) begin
                m_good++;
                if (m_good >= LOCK_CNT) begin m_state = 2; m_good = 0; end
            end else begin
                m_good = 0;
            end
        end else if (m_state == 2) begin
            if (ok) begin
                m_wrap = (m_prev == 14 && m_prun == 1 && c == 0) ? 1 : 0;
            end else begin
                m_state = 3; m_err = 1;
                if (m_errcnt < 15) m_errcnt++;
            end
        end else begin
            m_state = 1; m_good = 0;
        end
        m_prev = c;
        m_prun = r;
    endtask

    task automatic check_outputs();
        chk("state",   8'(state),   8'(m_state));
        chk("locked",  8'(locked),  8'((m_state == 2) ? 1 : 0));
        chk("err",     8'(err),     8'(m_err));
        chk("wrap",    8'(wrap),    8'(m_wrap));
        chk("err_cnt", 8'(err_cnt), 8'(m_errcnt));
    endtask

    task automatic tick(input int c, input int r);
        cnt_in   = c[3:0];
        run      = r[0];
        last_cnt = c;
        last_run = r;
        @(posedge clk);
        model_step(c, r);
        @(negedge clk);
        check_outputs();
        if (err === 1'b1) err_pulses++;
        if (wrap === 1'b1) wrap_pulses++;
    endtask

    // Drive the value a correctly behaving counter would show, with run=1.
    task automatic good();
        tick((last_run != 0) ? (last_cnt + 2) % 16 : last_cnt, 1);
    endtask

    task automatic bad();
        tick((last_cnt + 4) % 16, 1);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        last_cnt = 0;
        last_run = 0;
    endtask

    // Directed scenarios followed by a randomized walk.
    initial begin
        int c;
        int r;
        model_reset();
        err_pulses = 0; wrap_pulses = 0;
        last_cnt = 0; last_run = 0;
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Lock acquisition
        tick(0, 1);
        chk("acq_state", 8'(state), 8'd1);
        tick(2, 1);
        chk("acq_locked_early", 8'(locked), 8'd0);
        tick(4, 1);
        chk("lock_state", 8'(state), 8'd2);
        chk("lock_locked", 8'(locked), 8'd1);
        chk("lock_no_err", 8'(err_pulses), 8'd0);

        // Hold with run low, then run through the wrap
        for (int i = 0; i < 5; i++) tick(6, 0);
        chk("hold_no_err", 8'(err_pulses), 8'd0);
        for (int i = 0; i < 6; i++) good();
        chk("wrap_pulse", 8'(wrap), 8'd1);
        chk("wrap_count", 8'(wrap_pulses), 8'd1);
        chk("wrap_locked", 8'(locked), 8'd1);
        good();
        chk("wrap_one_cycle", 8'(wrap), 8'd0);

        // Skip error
        tick(4, 1);
        tick(8, 1);
        chk("skip_err", 8'(err), 8'd1);
        chk("skip_err_cnt", 8'(err_cnt), 8'd1);
        chk("skip_state_err", 8'(state), 8'd3);
        good();
        chk("skip_state_acq", 8'(state), 8'd1);
        chk("skip_unlocked", 8'(locked), 8'd0);
        good();
        good();
        chk("skip_relock", 8'(locked), 8'd1);

        // Odd value in LOCKED, then in ACQ
        tick(5, 1);
        chk("odd_locked_err", 8'(err), 8'd1);
        chk("odd_locked_cnt", 8'(err_cnt), 8'd2);
        tick(0, 1);
        good();
        tick(5, 1);
        chk("odd_acq_no_err", 8'(err), 8'd0);
        tick(0, 1);
        good();
        chk("odd_acq_delayed", 8'(locked), 8'd0);
        good();
        chk("odd_acq_relock", 8'(locked), 8'd1);

        // Randomized walk with occasional corrupted samples
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) c = int'($urandom_range(0, 15));
            else c = (last_run != 0) ? (last_cnt + 2) % 16 : last_cnt;
            tick(c, r);
        end

        // Saturation over 17 lock/error cycles
        apply_reset();
        tick(0, 1); good(); good();
        chk("sat_locked", 8'(locked), 8'd1);
        err_pulses = 0;
        for (int k = 1; k <= 17; k++) begin
            bad();
            chk("sat_cnt", 8'(err_cnt), 8'((k > 15) ? 15 : k));
            good(); good(); good();
        end
        chk("sat_pulses", 8'(err_pulses), 8'd17);
        chk("sat_final", 8'(err_cnt), 8'd15);

        // Asynchronous reset while LOCKED with err_cnt=3
        apply_reset();
        tick(0, 1); good(); good();
        for (int k = 0; k < 3; k++) begin
            bad(); good(); good(); good();
        end
        chk("ar_pre_cnt", 8'(err_cnt), 8'd3);
        chk("ar_pre_locked", 8'(locked), 8'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_state", 8'(state), 8'd0);
        chk("ar_locked", 8'(locked), 8'd0);
        chk("ar_err_cnt", 8'(err_cnt), 8'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        last_cnt = 0; last_run = 0;
        tick(6, 1);
        chk("ar_hunt_exit", 8'(state), 8'd1);
        good(); good();
        chk("ar_relock", 8'(locked), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/even_cnt_checker.md
EVEN_CNT_CHECKER -- requirements
Module: even_cnt_checker

Interface
REQ-001 Parameter LOCK_CNT, default 2, meaning the number of consecutive matching samples in ACQ needed to enter LOCKED (legal range 1..7).
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cnt_in  input  4  observed value from the even-step (0,2,...,14) run-gated counter.
REQ-005 run  input  1  the run qualifier presented to that counter in the same cycle.
REQ-006 locked  output  1  high while state is LOCKED.
REQ-007 err  output  1  one-cycle pulse on a sequence violation detected in LOCKED.
REQ-008 wrap  output  1  one-cycle pulse on a correct 14->0 step seen in LOCKED.
REQ-009 err_cnt  output  4  saturating count of err pulses.
REQ-010 state  output  2  current state: HUNT=00, ACQ=01, LOCKED=10, ERROR=11.

Function
REQ-011 All outputs SHALL be registered; a condition sampled at posedge k SHALL appear on outputs after posedge k and remain until posedge k+1.
REQ-012 Every posedge outside reset SHALL capture prev_cnt<=cnt_in and prev_run<=run, regardless of state.
REQ-013 Expected value SHALL be prev_run ? (prev_cnt+2) mod 16 : prev_cnt, computed with 4-bit wrap-around.
REQ-014 A sample SHALL match only if cnt_in equals expected and cnt_in[0]==0; any odd cnt_in SHALL be a mismatch.
REQ-015 HUNT: the first posedge after reset release SHALL capture the anchor only, without comparing, and go to ACQ with good_cnt=0.
REQ-016 ACQ: match -> good_cnt+1; when good_cnt+1 reaches LOCK_CNT, go to LOCKED; mismatch -> good_cnt=0 and stay in ACQ; err SHALL NOT pulse in ACQ.
REQ-017 LOCKED: match -> stay; mismatch -> go to ERROR, pulse err, and increment err_cnt.
REQ-018 ERROR SHALL last exactly one cycle, then go to ACQ with good_cnt=0 regardless of the sample; that sample is anchor only.
REQ-019 wrap SHALL pulse only in LOCKED on a matching sample with prev_cnt=14, prev_run=1, and cnt_in=0.
REQ-020 If a mismatch occurs where a wrap was expected, err SHALL pulse and wrap SHALL stay 0.
REQ-021 err_cnt SHALL saturate at 15; further errors SHALL still pulse err.
REQ-022 run held low with a constant cnt_in SHALL count as matching; in LOCKED it SHALL never raise err.

Reset
REQ-023 rst low SHALL immediately, without a clock, force: state=HUNT, locked=0, err=0, wrap=0, err_cnt=0, good_cnt=0, prev_cnt=0, prev_run=0.
REQ-024 Reset asserted mid-operation, in any state, SHALL abort that state fully; after release the block SHALL restart from HUNT with no retained lock or error count.
REQ-025 Reset release SHALL take effect on the first posedge with rst high, which is the HUNT capture edge.

Verification
REQ-026 Lock acquisition: release reset, drive run=1 with cnt_in 0,2,4 on successive edges -> state goes 00->01->10; locked rises after the 3rd edge; err=0 throughout.
REQ-027 Hold and wrap: in LOCKED, run=0 holding 6 for 5 cycles -> no err; then run=1 through 8,10,12,14,0 -> wrap pulses exactly one cycle after the edge sampling 0; locked stays 1.
REQ-028 Skip error: in LOCKED with run=1, present 4 then 8 -> err pulses one cycle, err_cnt=1, state goes 10->11->01, locked=0; two more good steps -> locked=1 again.
REQ-029 Odd value: in LOCKED, present cnt_in=5 -> err pulses and err_cnt increments; in ACQ, present 5 -> no err, good_cnt resets, and the lock is delayed by LOCK_CNT good steps.
REQ-030 Saturation: force 17 lock/error cycles -> err_cnt reads 15 after the 15th error and stays 15; err still pulses 17 times.
REQ-031 Async reset: drive rst low between clock edges while LOCKED with err_cnt=3 -> locked, err_cnt and state read 0 before the next posedge.
